// File: rtl/decimal_req_arbiter.sv
// Round-robin arbiter for ten requesters (0-9) with one-hot and binary grant,
// a forced dead cycle between grants, and hold-time preemption.
module decimal_req_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] req,
    input  logic       done,
    output logic [9:0] gnt,
    output logic [3:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q;
    logic [3:0] ptr_q;
    logic [7:0] hold_q;
    logic [9:0] gnt_q;
    logic [3:0] id_q;
    logic       preempt_q;

    logic       sel_found_d;
    logic [3:0] sel_idx_d;
    logic [4:0] cand_d;
    logic       owner_req_d;
    logic       hold_hit_d;
    logic       release_d;
    logic [3:0] ptr_next_d;

    // Cyclic scan starting at ptr; first requester found wins.
    always_comb begin
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        cand_d      = '0;
        for (int unsigned k = 0; k < 10; k++) begin
            cand_d = 5'(ptr_q) + 5'(k);
            if (cand_d >= 5'd10) begin
                cand_d = cand_d - 5'd10;
            end
            if (!sel_found_d && req[cand_d[3:0]]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = cand_d[3:0];
            end
        end
    end

    always_comb begin
        owner_req_d = |(req & gnt_q);
        hold_hit_d  = (hold_q == HOLD_LAST);
        release_d   = done || !owner_req_d || hold_hit_d;
        ptr_next_d  = (id_q == 4'd9) ? 4'd0 : id_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            id_q      <= '0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_found_d) begin
                        state_q <= GRANT;
                        gnt_q   <= 10'd1 << sel_idx_d;
                        id_q    <= sel_idx_d;
                        hold_q  <= '0;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        id_q      <= '0;
                        hold_q    <= '0;
                        ptr_q     <= ptr_next_d;
                        preempt_q <= hold_hit_d && !done && owner_req_d;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = (state_q == GRANT);
    assign preempt   = preempt_q;

endmodule

// File: doc/decimal_req_arbiter.md
# decimal_req_arbiter

Round-robin arbiter sharing one downstream resource among ten requesters whose request lines are numbered 0–9. It grants exactly one requester at a time and presents the grant both as a one-hot vector and as a 4-bit binary index. It sits in front of the decimal-to-binary encoding datapath and sequences access to it: arbitration, holding, release, and fairness rotation. A hold-time limit forcibly preempts owners that never release.

## Interface
- MAX_HOLD, default 16: maximum cycles one owner may hold the grant. Legal range 1–255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  10  request lines; bit i = requester i. Level-sensitive.
- done  input  1  current owner releases the resource. Sampled only while a grant is active.
- gnt  output  10  one-hot grant; all zero when no grant is active.
- gnt_id  output  4  binary index of the granted requester, 0–9. Equals 0 when no grant is active.
- gnt_valid  output  1  high while a grant is active. Equals |gnt.
- preempt  output  1  one-cycle pulse when a grant ends because of the hold limit.

## Operation
- All outputs are registered.
- States:
  - IDLE: gnt_valid=0.
  - GRANT: gnt_valid=1.
- Internal rotation pointer ptr[3:0] holds values 0–9.
- IDLE behaviour:
  - If req≠0 at a clock edge, select the first requester i with req[i]=1, scanning i = ptr, ptr+1, … cyclically modulo 10.
  - At that same edge: enter GRANT, gnt←one-hot(i), gnt_id←i, hold_cnt←0.
  - If req=0, remain in IDLE.
- GRANT behaviour:
  - hold_cnt increments by 1 each cycle spent in GRANT.
  - Release at an edge when any of these holds: done=1; req[gnt_id]=0; hold_cnt = MAX_HOLD−1.
  - On release: state←IDLE, gnt←0, gnt_id←0, ptr←(gnt_id==9) ? 0 : gnt_id+1.
  - preempt←1 for one cycle only if the hold limit was the sole release cause. If done=1 or the request dropped at the same edge, preempt stays 0.
- After every release there is exactly one IDLE cycle with gnt=0 (dead cycle) before the next grant. Two grants never overlap or abut.
- Requests from non-owners during GRANT are ignored until the next IDLE evaluation. Nothing is queued; requesters must hold req high.
- done asserted in IDLE is ignored.
- Fairness: the requester just served has the lowest priority at the next arbitration. The pointer wraps 9→0.
- Reset, asynchronous and effective immediately, including mid-grant:
  - state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0.
  - The first arbitration after reset favours requester 0.

## Timing
- Grant latency: req seen at edge k in IDLE → gnt/gnt_valid high after edge k, i.e. visible in cycle k+1.
- Release latency: done high at edge m → gnt low after edge m. The earliest new grant appears after edge m+1.
- Maximum continuous ownership is MAX_HOLD cycles. With MAX_HOLD=1, each grant lasts exactly one cycle.
- Worst-case wait for a continuously requesting requester: 9 × (MAX_HOLD+1) cycles.
- Both preempt and the gnt drop appear after the same edge.
- gnt_id, gnt and gnt_valid always change together.

## Test plan
- Reset, then req=10'b0000001000 → gnt=10'b0000001000, gnt_id=3, gnt_valid=1 one cycle after the request edge. Raise done → gnt=0 for exactly one cycle.
- req=10'b1111111111 held, done pulsed one cycle after each grant → gnt_id sequence 0,1,2,…,9,0, each grant separated by one dead cycle.
- MAX_HOLD=4, req[5] held high with done=0 → grant lasts exactly 4 cycles, preempt pulses coincident with the release, re-grant to 5 after one dead cycle. Repeat with done=1 on the 4th cycle → preempt=0.
- Owner 7 drops req[7] mid-grant while req[2] is high → release on the next edge, ptr=8, next grant to 2 (wrap 9→0→…→2).
- Assert rst_n=0 asynchronously mid-grant → gnt, gnt_valid and gnt_id clear without waiting for a clock edge. After release, req=10'b1000000001 → grant to 0.
- done pulsed in IDLE with req=0 → no state change, all outputs remain 0.
